// File: rtl/lsu_ctrl_gen.sv
// lsu_ctrl_gen: load/store unit controller between the AGU and a single data RAM port.
// Turns each accepted AGU request into one or two memory cmd/rsp handshakes.
// A strobed RAM gets a single write. A strobe-less RAM gets a read-modify-write.
// Load data is aligned and extended, and a single tagged writeback is returned.
module lsu_ctrl_gen #(
    parameter int XLEN    = 32,
    parameter int AW      = 30,
    parameter int TAG_W   = 4,
    parameter int BYTE_EN = 1,
    parameter int RSP_TMO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  agu_i_valid,
    output logic                  agu_o_ready,
    input  logic                  agu_i_read,
    input  logic                  agu_i_write,
    input  logic                  agu_i_usign,
    input  logic [1:0]            agu_i_size,
    input  logic [XLEN-1:0]       agu_i_addr,
    input  logic [XLEN-1:0]       agu_i_wdata,
    input  logic [TAG_W-1:0]      agu_i_itag,
    output logic                  lsu_mem_cmd_valid,
    input  logic                  mem_lsu_cmd_ready,
    output logic                  lsu_mem_cmd_read,
    output logic [AW-1:0]         lsu_mem_cmd_addr,
    output logic [XLEN-1:0]       lsu_mem_cmd_wdata,
    output logic [XLEN/8-1:0]     lsu_mem_cmd_wmask,
    input  logic                  mem_lsu_rsp_valid,
    output logic                  lsu_mem_rsp_ready,
    input  logic [XLEN-1:0]       mem_lsu_rsp_rdata,
    input  logic                  mem_lsu_rsp_err,
    output logic                  lsu_o_wbck_valid,
    input  logic                  wbck_i_ready,
    output logic [XLEN-1:0]       lsu_o_wbck_wdata,
    output logic [1:0]            lsu_o_wbck_cause,
    output logic [TAG_W-1:0]      lsu_o_wbck_itag
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);
    localparam logic [15:0] TMO_LAST = 16'(RSP_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_RSP     = 3'd2,
        S_MRG_CMD = 3'd3,
        S_MRG_RSP = 3'd4,
        S_WB      = 3'd5
    } state_t;

    // Byte lanes covered by an access of the given size, starting at lane 0.
    function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
        logic [NB-1:0] m;
        int            n;
        m = '0;
        n = 32'sd1 <<< size;
        for (int i = 0; i < NB; i++) begin
            if (i < n) m[i] = 1'b1;
            else       m[i] = 1'b0;
        end
        return m;
    endfunction

    // An access is misaligned when its low address bits are not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] size);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lo[0];
            2'b10:   m = |lo[1:0];
            2'b11:   m = (XLEN == 64) ? (|lo) : 1'b1;
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Copy right-aligned store data into every lane so any strobe pattern finds its bytes.
    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] size);
        logic [XLEN-1:0] r;
        case (size)
            2'b00:   r = {NB{d[7:0]}};
            2'b01:   r = {(NB/2){d[15:0]}};
            2'b10:   r = {(NB/4){d[31:0]}};
            2'b11:   r = d;
            default: r = d;
        endcase
        return r;
    endfunction

    // Widen a byte strobe into a bit mask.
    function automatic logic [XLEN-1:0] expand(input logic [NB-1:0] m);
        logic [XLEN-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    state_t             r_state, w_state_nxt;
    logic               r_is_store, r_usign;
    logic [1:0]         r_size;
    logic [XLEN-1:0]    r_addr, r_wdata, r_merged, r_wb_data;
    logic [NB-1:0]      r_mask;
    logic [TAG_W-1:0]   r_itag;
    logic [1:0]         r_wb_cause;
    logic [15:0]        r_cnt, w_cnt_nxt;
    logic               w_accept, w_misal, w_ld_wb, w_ld_merge;
    logic [XLEN-1:0]    w_wb_data_nxt, w_shifted, w_load_ext;
    logic [1:0]         w_wb_cause_nxt;

    assign w_accept  = agu_i_valid && (r_state == S_IDLE);
    assign w_misal   = is_misaligned(agu_i_addr[2:0], agu_i_size);
    assign w_shifted = mem_lsu_rsp_rdata >> {r_addr[OFS-1:0], 3'b000};

    // Pick the addressed byte/half/word out of the response and extend it.
    always_comb begin
        w_load_ext = '0;
        case (r_size)
            2'b00:   w_load_ext = r_usign ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
            2'b01:   w_load_ext = r_usign ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
            2'b10:   w_load_ext = r_usign ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
            2'b11:   w_load_ext = mem_lsu_rsp_rdata;
            default: w_load_ext = '0;
        endcase
    end

    // Next-state decode and handshake outputs driven from the current state.
    always_comb begin
        w_state_nxt       = r_state;
        w_ld_wb           = 1'b0;
        w_ld_merge        = 1'b0;
        w_wb_data_nxt     = '0;
        w_wb_cause_nxt    = 2'b00;
        w_cnt_nxt         = 16'd0;
        agu_o_ready       = 1'b0;
        lsu_mem_cmd_valid = 1'b0;
        lsu_mem_cmd_read  = 1'b0;
        lsu_mem_cmd_addr  = '0;
        lsu_mem_cmd_wdata = '0;
        lsu_mem_cmd_wmask = '0;
        lsu_mem_rsp_ready = 1'b0;
        lsu_o_wbck_valid  = 1'b0;
        lsu_o_wbck_wdata  = '0;
        lsu_o_wbck_cause  = 2'b00;
        lsu_o_wbck_itag   = '0;
        case (r_state)
            S_IDLE: begin
                agu_o_ready       = 1'b1;
                lsu_mem_rsp_ready = 1'b1;   // stray responses are swallowed here
                if (agu_i_valid) begin
                    if (w_misal) begin
                        w_state_nxt    = S_WB;
                        w_ld_wb        = 1'b1;
                        w_wb_cause_nxt = 2'b01;
                    end else if (!agu_i_read && !agu_i_write) begin
                        // Neither load nor store: complete as a no-op without touching memory.
                        w_state_nxt = S_WB;
                        w_ld_wb     = 1'b1;
                    end else begin
                        w_state_nxt = S_CMD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CMD, S_MRG_CMD: begin
                lsu_mem_cmd_valid = 1'b1;
                lsu_mem_cmd_addr  = AW'(r_addr[XLEN-1:OFS]);
                if (r_state == S_CMD) begin
                    lsu_mem_cmd_read  = !r_is_store || (BYTE_EN == 0);
                    lsu_mem_cmd_wdata = r_wdata;
                    lsu_mem_cmd_wmask = (BYTE_EN != 0) ? r_mask : {NB{1'b1}};
                end else begin
                    lsu_mem_cmd_read  = 1'b0;
                    lsu_mem_cmd_wdata = r_merged;
                    lsu_mem_cmd_wmask = {NB{1'b1}};
                end
                if (mem_lsu_cmd_ready) begin
                    w_state_nxt = (r_state == S_CMD) ? S_RSP : S_MRG_RSP;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RSP, S_MRG_RSP: begin
                lsu_mem_rsp_ready = 1'b1;
                if (mem_lsu_rsp_valid) begin
                    if (mem_lsu_rsp_err) begin
                        w_state_nxt    = S_WB;
                        w_ld_wb        = 1'b1;
                        w_wb_cause_nxt = 2'b10;
                    end else if ((r_state == S_RSP) && r_is_store && (BYTE_EN == 0)) begin
                        w_state_nxt = S_MRG_CMD;
                        w_ld_merge  = 1'b1;
                    end else begin
                        w_state_nxt   = S_WB;
                        w_ld_wb       = 1'b1;
                        w_wb_data_nxt = r_is_store ? '0 : w_load_ext;
                    end
                end else if ((RSP_TMO != 0) && (r_cnt == TMO_LAST)) begin
                    w_state_nxt    = S_WB;
                    w_ld_wb        = 1'b1;
                    w_wb_cause_nxt = 2'b11;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_WB: begin
                lsu_o_wbck_valid = 1'b1;
                lsu_o_wbck_wdata = r_wb_data;
                lsu_o_wbck_cause = r_wb_cause;
                lsu_o_wbck_itag  = r_itag;
                if (wbck_i_ready) w_state_nxt = S_IDLE;
                else              w_state_nxt = S_WB;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, request latches, merge word, writeback payload and response timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_usign    <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_itag     <= '0;
            r_merged   <= '0;
            r_wb_data  <= '0;
            r_wb_cause <= 2'b00;
            r_cnt      <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_is_store <= agu_i_write;
                r_usign    <= agu_i_usign;
                r_size     <= agu_i_size;
                r_addr     <= agu_i_addr;
                r_wdata    <= replicate(agu_i_wdata, agu_i_size);
                r_mask     <= size_mask(agu_i_size) << agu_i_addr[OFS-1:0];
                r_itag     <= agu_i_itag;
            end
            if (w_ld_merge) begin
                r_merged <= (r_wdata & expand(r_mask)) | (mem_lsu_rsp_rdata & ~expand(r_mask));
            end
            if (w_ld_wb) begin
                r_wb_data  <= w_wb_data_nxt;
                r_wb_cause <= w_wb_cause_nxt;
            end
        end
    end
endmodule

// File: tb/tb_lsu_ctrl_gen.sv
// Bench for lsu_ctrl_gen: a strobed instance (sel=0) and a read-modify-write instance (sel=1),
// both with an 8-cycle response timeout, share stimulus. Results are compared against a byte-level
// reference memory and arithmetic expectations.
module tb_lsu_ctrl_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        agu_valid, agu_read, agu_write, agu_usign;
    logic [1:0]  agu_size;
    logic [31:0] agu_addr, agu_wdata;
    logic [3:0]  agu_itag;
    logic        cmd_ready, rsp_valid, rsp_err, wbck_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  agu_v;

    logic [1:0]  a_ready, c_valid, c_read, r_ready, w_valid;
    logic [29:0] c_addr [2];
    logic [31:0] c_wdata [2];
    logic [3:0]  c_wmask [2];
    logic [31:0] w_wdata [2];
    logic [1:0]  w_cause [2];
    logic [3:0]  w_itag [2];

    assign agu_v = sel ? {agu_valid, 1'b0} : {1'b0, agu_valid};

    lsu_ctrl_gen #(.XLEN(32), .AW(30), .TAG_W(4), .BYTE_EN(1), .RSP_TMO(8)) u_be (
        .clk(clk), .rst(rst), .agu_i_valid(agu_v[0]), .agu_o_ready(a_ready[0]),
        .agu_i_read(agu_read), .agu_i_write(agu_write), .agu_i_usign(agu_usign),
        .agu_i_size(agu_size), .agu_i_addr(agu_addr), .agu_i_wdata(agu_wdata), .agu_i_itag(agu_itag),
        .lsu_mem_cmd_valid(c_valid[0]), .mem_lsu_cmd_ready(cmd_ready), .lsu_mem_cmd_read(c_read[0]),
        .lsu_mem_cmd_addr(c_addr[0]), .lsu_mem_cmd_wdata(c_wdata[0]), .lsu_mem_cmd_wmask(c_wmask[0]),
        .mem_lsu_rsp_valid(rsp_valid), .lsu_mem_rsp_ready(r_ready[0]), .mem_lsu_rsp_rdata(rsp_rdata),
        .mem_lsu_rsp_err(rsp_err), .lsu_o_wbck_valid(w_valid[0]), .wbck_i_ready(wbck_ready),
        .lsu_o_wbck_wdata(w_wdata[0]), .lsu_o_wbck_cause(w_cause[0]), .lsu_o_wbck_itag(w_itag[0]));

    lsu_ctrl_gen #(.XLEN(32), .AW(30), .TAG_W(4), .BYTE_EN(0), .RSP_TMO(8)) u_rmw (
        .clk(clk), .rst(rst), .agu_i_valid(agu_v[1]), .agu_o_ready(a_ready[1]),
        .agu_i_read(agu_read), .agu_i_write(agu_write), .agu_i_usign(agu_usign),
        .agu_i_size(agu_size), .agu_i_addr(agu_addr), .agu_i_wdata(agu_wdata), .agu_i_itag(agu_itag),
        .lsu_mem_cmd_valid(c_valid[1]), .mem_lsu_cmd_ready(cmd_ready), .lsu_mem_cmd_read(c_read[1]),
        .lsu_mem_cmd_addr(c_addr[1]), .lsu_mem_cmd_wdata(c_wdata[1]), .lsu_mem_cmd_wmask(c_wmask[1]),
        .mem_lsu_rsp_valid(rsp_valid), .lsu_mem_rsp_ready(r_ready[1]), .mem_lsu_rsp_rdata(rsp_rdata),
        .mem_lsu_rsp_err(rsp_err), .lsu_o_wbck_valid(w_valid[1]), .wbck_i_ready(wbck_ready),
        .lsu_o_wbck_wdata(w_wdata[1]), .lsu_o_wbck_cause(w_cause[1]), .lsu_o_wbck_itag(w_itag[1]));

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mem [256];       // memory as seen by the DUT
    logic [7:0]  ref_mem [1024];  // byte-level reference memory

    int          res_lat, res_ncmd;
    logic [31:0] res_wd;
    logic [1:0]  res_cause;
    logic [3:0]  res_tag;
    logic        cmd_rd [2];
    logic [29:0] cmd_ad [2];
    logic [31:0] cmd_wd [2];
    logic [3:0]  cmd_wm [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int k = 0; k < 4; k++) ref_mem[4*w+k] = v[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one request and act as memory and commit until the writeback handshake.
    task automatic run_txn(input logic rd, input logic wr, input logic us, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] tg,
                           input int dly, input int cs, input bit er, input int stall);
        int cyc, t_acc, pend_dly, cs_left, st_left, idx;
        bit acc, pend, done, seen, drop;
        logic [31:0] pend_data, snap_d;
        logic [1:0]  snap_c;
        logic [3:0]  snap_t;
        agu_valid = 1'b1; agu_read = rd; agu_write = wr; agu_usign = us;
        agu_size = sz; agu_addr = ad; agu_wdata = wd; agu_itag = tg;
        cmd_ready = 1'b1; wbck_ready = 1'b1;
        cs_left = cs; st_left = stall; pend_dly = 0; pend_data = 32'h0;
        acc = 1'b0; pend = 1'b0; done = 1'b0; seen = 1'b0;
        snap_d = 32'h0; snap_c = 2'b00; snap_t = 4'h0;
        res_ncmd = 0; res_lat = -1; cyc = 0; t_acc = 0;
        while (!done && cyc < 300) begin
            if (c_valid[sel]) begin
                if (cs_left > 0) begin cmd_ready = 1'b0; cs_left--; end
                else cmd_ready = 1'b1;
            end
            if (w_valid[sel]) begin
                if (!seen) begin
                    seen = 1'b1; res_lat = cyc - t_acc;
                    snap_d = w_wdata[sel]; snap_c = w_cause[sel]; snap_t = w_itag[sel];
                end else begin
                    chk("wbck_hold_data", w_wdata[sel], snap_d);
                    chk("wbck_hold_cause", {30'd0, w_cause[sel]}, {30'd0, snap_c});
                    chk("wbck_hold_itag", {28'd0, w_itag[sel]}, {28'd0, snap_t});
                end
                if (st_left > 0) begin wbck_ready = 1'b0; st_left--; end
                else wbck_ready = 1'b1;
            end
            if (!acc && agu_valid && a_ready[sel]) begin acc = 1'b1; t_acc = cyc; end
            if (c_valid[sel] && cmd_ready) begin
                idx = int'(c_addr[sel][7:0]);
                if (res_ncmd < 2) begin
                    cmd_rd[res_ncmd] = c_read[sel]; cmd_ad[res_ncmd] = c_addr[sel];
                    cmd_wd[res_ncmd] = c_wdata[sel]; cmd_wm[res_ncmd] = c_wmask[sel];
                end
                pend = 1'b1; pend_dly = dly; pend_data = mem[idx];
                if (!c_read[sel] && !(er && res_ncmd == 0)) begin
                    for (int k = 0; k < 4; k++)
                        if (c_wmask[sel][k]) mem[idx][8*k +: 8] = c_wdata[sel][8*k +: 8];
                end
                res_ncmd++;
                cs_left = cs;
            end
            drop = rsp_valid && r_ready[sel];
            if (w_valid[sel] && wbck_ready) begin
                done = 1'b1;
                res_wd = w_wdata[sel]; res_cause = w_cause[sel]; res_tag = w_itag[sel];
            end
            cycle();
            cyc++;
            if (acc) agu_valid = 1'b0;
            if (drop) begin rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 32'h0; end
            if (pend) begin
                if (pend_dly == 0) begin
                    rsp_valid = 1'b1; rsp_rdata = pend_data; rsp_err = er && (res_ncmd == 1); pend = 1'b0;
                end else begin
                    pend_dly--;
                end
            end
        end
        n_chk++;
        assert (done) else begin
            n_err++;
            $error("FAIL txn_bound: observed=no_writeback expected=writeback within 300 cycles");
        end
        agu_valid = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; cmd_ready = 1'b1; wbck_ready = 1'b1;
    endtask

    // Work out the expected outcome from the access rules, run the request, compare.
    task automatic do_txn(input string nm, input logic rd, input logic wr, input logic us,
                          input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] tg, input int dly, input int cs, input bit er, input int stall);
        int nb, e_lat, e_ncmd, widx;
        bit misal, store, rmw, tmo, be;
        logic [31:0] e_wd, e_w0;
        logic [1:0]  e_cause;
        logic [3:0]  e_m0;
        be = (sel == 1'b0);
        nb = 1 << sz;
        misal = (sz == 2'd3) || ((ad % nb) != 0);
        store = wr;
        rmw = store && !be;
        tmo = (dly >= 8);
        widx = int'(ad >> 2);
        e_wd = 32'h0;
        e_m0 = 4'((32'd1 << nb) - 32'd1) << ad[1:0];
        for (int i = 0; i < 4; i++) e_w0[8*i +: 8] = wd[8*(i % nb) +: 8];
        if (misal) begin
            e_cause = 2'b01; e_lat = 1; e_ncmd = 0;
        end else if (er) begin
            e_cause = 2'b10; e_lat = 3 + cs + dly; e_ncmd = 1;
        end else if (tmo) begin
            e_cause = 2'b11; e_lat = 10 + cs; e_ncmd = 1;
        end else begin
            e_cause = 2'b00;
            e_ncmd = rmw ? 2 : 1;
            e_lat = rmw ? 5 + 2*(cs + dly) : 3 + cs + dly;
            if (!store) begin
                for (int i = 0; i < nb; i++) e_wd[8*i +: 8] = ref_mem[ad + i];
                if (!us && nb == 1 && e_wd[7])  e_wd = e_wd | 32'hFFFF_FF00;
                if (!us && nb == 2 && e_wd[15]) e_wd = e_wd | 32'hFFFF_0000;
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[ad + i] = wd[8*i +: 8];
            end
        end
        run_txn(rd, wr, us, sz, ad, wd, tg, dly, cs, er, stall);
        chk({nm, "_cause"}, {30'd0, res_cause}, {30'd0, e_cause});
        chk({nm, "_wdata"}, res_wd, e_wd);
        chk({nm, "_itag"}, {28'd0, res_tag}, {28'd0, tg});
        chk({nm, "_latency"}, res_lat, e_lat);
        chk({nm, "_ncmd"}, res_ncmd, e_ncmd);
        if (res_ncmd > 0 && e_ncmd > 0) begin
            chk({nm, "_cmd_addr"}, {2'b00, cmd_ad[0]}, 32'(widx));
            chk({nm, "_cmd_read"}, {31'd0, cmd_rd[0]}, {31'd0, (!store || rmw)});
            if (store && be) begin
                chk({nm, "_cmd_wdata"}, cmd_wd[0], e_w0);
                chk({nm, "_cmd_wmask"}, {28'd0, cmd_wm[0]}, {28'd0, e_m0});
            end
            if (rmw) chk({nm, "_cmd_wmask"}, {28'd0, cmd_wm[0]}, 32'hF);
        end
        if (rmw && e_ncmd == 2 && res_ncmd == 2) begin
            chk({nm, "_mrg_read"}, {31'd0, cmd_rd[1]}, 32'd0);
            chk({nm, "_mrg_wmask"}, {28'd0, cmd_wm[1]}, 32'hF);
            chk({nm, "_mrg_wdata"}, cmd_wd[1], ref_word(widx));
        end
        if (!misal) chk({nm, "_mem_word"}, mem[widx], ref_word(widx));
    endtask

    // Inject one response while idle and require that nothing is written back.
    task automatic stray_rsp(input string nm);
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF; rsp_err = 1'b0;
        cycle();
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_no_wbck"}, {31'd0, w_valid[sel]}, 32'd0);
            chk({nm, "_ready"}, {31'd0, a_ready[sel]}, 32'd1);
            cycle();
        end
    endtask

    initial begin
        logic [31:0] ad, wd;
        logic [1:0]  sz;
        logic        wr, rd;
        int          nb;
        rst = 1'b1; sel = 1'b0;
        agu_valid = 1'b0; agu_read = 1'b0; agu_write = 1'b0; agu_usign = 1'b0;
        agu_size = 2'b00; agu_addr = 32'h0; agu_wdata = 32'h0; agu_itag = 4'h0;
        cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 32'h0; wbck_ready = 1'b1;
        for (int w = 0; w < 256; w++) set_word(w, $urandom);
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        for (int s = 0; s < 2; s++) begin
            chk("rst_agu_ready", {31'd0, a_ready[s]}, 32'd1);
            chk("rst_rsp_ready", {31'd0, r_ready[s]}, 32'd1);
            chk("rst_cmd_valid", {31'd0, c_valid[s]}, 32'd0);
            chk("rst_wbck_valid", {31'd0, w_valid[s]}, 32'd0);
            chk("rst_wbck_wdata", w_wdata[s], 32'd0);
        end

        // Directed cases on the strobed instance.
        sel = 1'b0;
        set_word(32'h40, 32'h80FF_1234);
        do_txn("lb", 1'b1, 1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 4'h3, 0, 0, 1'b0, 0);
        chk("lb_const", res_wd, 32'hFFFF_FF80);
        chk("lb_const_addr", {2'b00, cmd_ad[0]}, 32'h40);
        do_txn("lhu", 1'b1, 1'b0, 1'b1, 2'b01, 32'h102, 32'h0, 4'h4, 0, 0, 1'b0, 0);
        chk("lhu_const", res_wd, 32'h0000_80FF);
        do_txn("lw_mis", 1'b1, 1'b0, 1'b0, 2'b10, 32'h102, 32'h0, 4'h5, 0, 0, 1'b0, 0);
        chk("lw_mis_cause", {30'd0, res_cause}, 32'd1);
        do_txn("sb_be", 1'b0, 1'b1, 1'b0, 2'b00, 32'h101, 32'hAB, 4'h6, 0, 0, 1'b0, 0);
        chk("sb_be_wdata", cmd_wd[0], 32'hABAB_ABAB);
        chk("sb_be_wmask", {28'd0, cmd_wm[0]}, 32'h2);
        do_txn("ld_err", 1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 4'h7, 0, 0, 1'b1, 3);
        chk("ld_err_const", {30'd0, res_cause}, 32'd2);
        do_txn("ld_tmo", 1'b1, 1'b0, 1'b0, 2'b10, 32'h200, 32'h0, 4'h8, 1000, 0, 1'b0, 0);
        chk("ld_tmo_const", {30'd0, res_cause}, 32'd3);
        stray_rsp("tmo_late");
        do_txn("ld_edge", 1'b1, 1'b0, 1'b0, 2'b10, 32'h204, 32'h0, 4'h9, 7, 0, 1'b0, 0);

        // Reset while waiting for a response.
        agu_valid = 1'b1; agu_read = 1'b1; agu_write = 1'b0; agu_size = 2'b10;
        agu_addr = 32'h300; agu_itag = 4'hA;
        cycle();
        agu_valid = 1'b0;
        cycle();
        cycle();
        chk("abort_in_rsp", {31'd0, r_ready[0]}, 32'd1);
        chk("abort_no_cmd", {31'd0, c_valid[0]}, 32'd0);
        chk("abort_no_ready", {31'd0, a_ready[0]}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_agu_ready", {31'd0, a_ready[0]}, 32'd1);
        chk("abort_no_wbck", {31'd0, w_valid[0]}, 32'd0);
        stray_rsp("abort_late");
        do_txn("after_abort", 1'b1, 1'b0, 1'b1, 2'b00, 32'h301, 32'h0, 4'hB, 1, 1, 1'b0, 0);

        // Read-modify-write instance.
        sel = 1'b1;
        set_word(32'h40, 32'h1122_3344);
        do_txn("sb_rmw", 1'b0, 1'b1, 1'b0, 2'b00, 32'h101, 32'hAB, 4'hC, 0, 0, 1'b0, 0);
        chk("sb_rmw_merged", cmd_wd[1], 32'h1122_AB44);
        chk("sb_rmw_lat", res_lat, 32'd5);

        // Random traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int n = 0; n < 30; n++) begin
                sz = 2'($urandom_range(0, 2));
                nb = 1 << sz;
                ad = 32'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) != 0) ad = ad & ~(32'(nb) - 32'd1);
                wr = 1'($urandom_range(0, 1));
                rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
                wd = $urandom;
                do_txn("rand", rd, wr, 1'($urandom_range(0, 1)), sz, ad, wd, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                       $urandom_range(0, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
